alu_hold: RTL and testbench
===========================

Name: alu_hold

Overview:
- 6502 ALU with its input latches (AI, BI) and output hold register (ADD). Directly upstream of the S/AC/X/Y register stage.
- Operands are latched from the internal buses in one cycle. A result is computed on an execute strobe and then held on o_add, with carry, overflow and half-carry flags, until the next execute.
- Downstream registers load o_add on a later falling edge.

Parameters:
- ADD_RESET, 8'h00, value of o_add after reset

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_reset_n  in  1  reset; synchronous, active-low
- i_db  in  8  data bus
- i_sb  in  8  special bus
- i_adl  in  8  address-low bus
- i_load_ai_sb  in  1  AI <= i_sb
- i_load_ai_zero  in  1  AI <= 8'h00
- i_load_bi_db  in  1  BI <= i_db
- i_load_bi_db_n  in  1  BI <= ~i_db
- i_load_bi_adl  in  1  BI <= i_adl
- i_op  in  3  0 SUMS, 1 ANDS, 2 EORS, 3 ORS, 4 SRS; 5-7 reserved
- i_carry_in  in  1  carry into bit 0 (SUMS) / bit 7 (SRS)
- i_daa  in  1  decimal add adjust (SUMS only)
- i_dsa  in  1  decimal subtract adjust (SUMS only)
- i_execute  in  1  compute and capture result into hold register
- o_add  out  8  held result
- o_acr  out  1  held carry
- o_avr  out  1  held overflow
- o_hc  out  1  held half-carry (bit 3 carry out)

Behaviour:
- Reset (i_reset_n low at a rising edge) has priority over every other input:
  - AI = 0, BI = 0
  - o_add = ADD_RESET
  - o_acr = o_avr = o_hc = 0
- AI load priority: zero > sb. With no AI load strobe, AI holds.
- BI load priority: adl > db_n > db. With no BI load strobe, BI holds.
- Execute uses AI/BI values from before the edge.
  - Load and execute in the same cycle: the result uses the old operands; the new operands land in AI/BI.
  - Latency: load in cycle N, execute in cycle N+1, o_add valid after edge N+1.
- Without i_execute, o_add and all flags hold indefinitely.
- SUMS:
  - s9 = AI + BI + i_carry_in, computed 9 bits wide.
  - bin = s9[7:0]; ACR = s9[8].
  - HC = carry out of bit 3 of AI[3:0] + BI[3:0] + i_carry_in.
  - AVR = (AI[7] == BI[7]) && (bin[7] != AI[7]).
- Decimal add (i_daa = 1):
  - Add 6 to the low nibble if HC or bin[3:0] > 9.
  - Add 0x60 if ACR, or if the intermediate high nibble > 9; when this happens, ACR = 1.
  - Result is mod 256.
  - AVR and HC are reported from the binary computation.
- Decimal subtract (i_dsa = 1):
  - Subtract 6 from the low nibble if HC = 0.
  - Subtract 0x60 if ACR = 0.
  - ACR stays the binary carry.
- i_daa and i_dsa both high: treated as no adjust.
- i_daa or i_dsa with a non-SUMS op: ignored.
- ANDS / EORS / ORS: bitwise AI op BI; ACR = AVR = HC = 0.
- SRS: o_add = {i_carry_in, AI[7:1]}; ACR = AI[0]; AVR = HC = 0. BI is ignored.
- Reserved op: o_add = 8'h00, all flags 0.
- Subtraction convention: caller loads BI via db_n and drives i_carry_in = 1 (no borrow).
- Reset asserted mid-sequence discards any pending operand loads and any execute strobe in that cycle.

Test Plan:
- Reset with all strobes high and random buses -> o_add = 8'h00, o_acr = o_avr = o_hc = 0; AI/BI both 0 (verified by executing ORS next -> 8'h00).
- Load AI = 8'h50 (sb), BI = 8'h50 (db); then SUMS with carry 0 -> o_add = 8'hA0, ACR = 0, AVR = 1, HC = 0. Result holds for 5 idle cycles.
- BCD add: AI = 8'h58, BI = 8'h46, carry 1, i_daa -> o_add = 8'h05, ACR = 1.
- BCD subtract: AI = 8'h12, BI via db_n from 8'h21, carry 1, i_dsa -> o_add = 8'h91, ACR = 0.
- SRS with AI = 8'h81, carry 1 -> o_add = 8'hC0, ACR = 1.
- Execute ANDS on AI = 8'hF0, BI = 8'h3C while simultaneously loading AI zero and BI from adl = 8'hFF -> o_add = 8'h30. Next ORS -> 8'hFF.
- All three BI strobes high with adl = 8'h11, db = 8'h22, then ORS with AI = 0 -> o_add = 8'h11.

Source files
------------

// File: rtl/alu_hold_if.sv
// ALU hold bus: operand buses, load strobes, op select and held result.
// The master drives buses and strobes; the ALU (slave) returns the result.
interface alu_hold_if;
  logic [7:0] i_db;
  logic [7:0] i_sb;
  logic [7:0] i_adl;
  logic       i_load_ai_sb;
  logic       i_load_ai_zero;
  logic       i_load_bi_db;
  logic       i_load_bi_db_n;
  logic       i_load_bi_adl;
  logic [2:0] i_op;
  logic       i_carry_in;
  logic       i_daa;
  logic       i_dsa;
  logic       i_execute;
  logic [7:0] o_add;
  logic       o_acr;
  logic       o_avr;
  logic       o_hc;

  modport master (
    output i_db, i_sb, i_adl,
    output i_load_ai_sb, i_load_ai_zero,
    output i_load_bi_db, i_load_bi_db_n, i_load_bi_adl,
    output i_op, i_carry_in, i_daa, i_dsa, i_execute,
    input  o_add, o_acr, o_avr, o_hc
  );

  modport slave (
    input  i_db, i_sb, i_adl,
    input  i_load_ai_sb, i_load_ai_zero,
    input  i_load_bi_db, i_load_bi_db_n, i_load_bi_adl,
    input  i_op, i_carry_in, i_daa, i_dsa, i_execute,
    output o_add, o_acr, o_avr, o_hc
  );
endinterface

// File: rtl/alu_hold.sv
// 6502 ALU: AI/BI operand latches, binary/BCD adder, logic ops,
// shift right, and a hold register for the result and flags.
module alu_hold #(
  parameter logic [7:0] ADD_RESET = 8'h00
) (
  input logic       i_clk,
  input logic       i_reset_n,
  alu_hold_if.slave bus
);

  typedef enum logic [2:0] {
    OP_SUMS = 3'd0,
    OP_ANDS = 3'd1,
    OP_EORS = 3'd2,
    OP_ORS  = 3'd3,
    OP_SRS  = 3'd4
  } op_e;

  logic [7:0] ai_q, ai_d;
  logic [7:0] bi_q, bi_d;
  logic [7:0] add_q, add_d;
  logic       acr_q, acr_d;
  logic       avr_q, avr_d;
  logic       hc_q, hc_d;

  logic [8:0] s9;
  logic [7:0] bin;
  logic       bc, bh, bv;
  logic       dadd, dsub;
  logic [7:0] lo_adj;
  logic       hi_fix;
  logic [7:0] dec_add;
  logic [7:0] dec_sub;
  logic [7:0] res;
  logic       res_c, res_v, res_h;

  always_comb begin
    ai_d = ai_q;
    if (bus.i_load_ai_zero)
      ai_d = 8'h00;
    else if (bus.i_load_ai_sb)
      ai_d = bus.i_sb;
  end

  always_comb begin
    bi_d = bi_q;
    if (bus.i_load_bi_adl)
      bi_d = bus.i_adl;
    else if (bus.i_load_bi_db_n)
      bi_d = ~bus.i_db;
    else if (bus.i_load_bi_db)
      bi_d = bus.i_db;
  end

  // Half-carry is the carry into bit 4, recovered from the sum.
  assign s9  = {1'b0, ai_q} + {1'b0, bi_q} + {8'h00, bus.i_carry_in};
  assign bin = s9[7:0];
  assign bc  = s9[8];
  assign bh  = s9[4] ^ ai_q[4] ^ bi_q[4];
  assign bv  = (ai_q[7] == bi_q[7]) && (bin[7] != ai_q[7]);

  assign dadd = bus.i_daa & ~bus.i_dsa;
  assign dsub = bus.i_dsa & ~bus.i_daa;

  assign lo_adj  = (bh || (bin[3:0] > 4'd9)) ? bin + 8'h06 : bin;
  assign hi_fix  = bc || (lo_adj[7:4] > 4'd9);
  assign dec_add = hi_fix ? lo_adj + 8'h60 : lo_adj;
  assign dec_sub = bin - (bh ? 8'h00 : 8'h06)
                       - (bc ? 8'h00 : 8'h60);

  always_comb begin
    res   = 8'h00;
    res_c = 1'b0;
    res_v = 1'b0;
    res_h = 1'b0;
    unique case (1'b1)
      (bus.i_op == OP_SUMS): begin
        res_v = bv;
        res_h = bh;
        if (dadd) begin
          res   = dec_add;
          res_c = bc | hi_fix;
        end else if (dsub) begin
          res   = dec_sub;
          res_c = bc;
        end else begin
          res   = bin;
          res_c = bc;
        end
      end
      (bus.i_op == OP_ANDS): res = ai_q & bi_q;
      (bus.i_op == OP_EORS): res = ai_q ^ bi_q;
      (bus.i_op == OP_ORS):  res = ai_q | bi_q;
      (bus.i_op == OP_SRS): begin
        res   = {bus.i_carry_in, ai_q[7:1]};
        res_c = ai_q[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    add_d = add_q;
    acr_d = acr_q;
    avr_d = avr_q;
    hc_d  = hc_q;
    if (bus.i_execute) begin
      add_d = res;
      acr_d = res_c;
      avr_d = res_v;
      hc_d  = res_h;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      ai_q  <= 8'h00;
      bi_q  <= 8'h00;
      add_q <= ADD_RESET;
      acr_q <= 1'b0;
      avr_q <= 1'b0;
      hc_q  <= 1'b0;
    end else begin
      ai_q  <= ai_d;
      bi_q  <= bi_d;
      add_q <= add_d;
      acr_q <= acr_d;
      avr_q <= avr_d;
      hc_q  <= hc_d;
    end
  end

  assign bus.o_add = add_q;
  assign bus.o_acr = acr_q;
  assign bus.o_avr = avr_q;
  assign bus.o_hc  = hc_q;

endmodule

// File: tb/tb_alu_hold.sv
// Directed bench for alu_hold; expected results go through a
// scoreboard queue packed as {add, acr, avr, hc}.
module tb_alu_hold;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  logic [10:0] sb_q[$];

  alu_hold_if bus ();

  alu_hold #(.ADD_RESET(8'h00)) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.i_load_ai_sb   = 1'b0;
    bus.i_load_ai_zero = 1'b0;
    bus.i_load_bi_db   = 1'b0;
    bus.i_load_bi_db_n = 1'b0;
    bus.i_load_bi_adl  = 1'b0;
    bus.i_execute      = 1'b0;
    bus.i_daa          = 1'b0;
    bus.i_dsa          = 1'b0;
    bus.i_carry_in     = 1'b0;
    bus.i_op           = 3'd0;
  endtask

  task automatic chk(input string tag);
    logic [10:0] obs;
    logic [10:0] exp;
    obs = {bus.o_add, bus.o_acr, bus.o_avr, bus.o_hc};
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $error("FAIL %s obs=%h exp=<empty queue>", tag, obs);
    end else begin
      exp = sb_q.pop_front();
      assert (obs === exp) else begin
        bad++;
        $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
    end
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] b,
                      input logic neg);
    bus.i_sb           = a;
    bus.i_db           = b;
    bus.i_load_ai_sb   = 1'b1;
    bus.i_load_bi_db   = ~neg;
    bus.i_load_bi_db_n = neg;
    cyc();
    clr();
  endtask

  task automatic exec(input logic [2:0] op, input logic cin,
                      input logic daa, input logic dsa,
                      input logic [10:0] e, input string tag);
    bus.i_op       = op;
    bus.i_carry_in = cin;
    bus.i_daa      = daa;
    bus.i_dsa      = dsa;
    bus.i_execute  = 1'b1;
    sb_q.push_back(e);
    cyc();
    clr();
    chk(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.i_load_ai_sb   = 1'b1;
    bus.i_load_ai_zero = 1'b1;
    bus.i_load_bi_db   = 1'b1;
    bus.i_load_bi_db_n = 1'b1;
    bus.i_load_bi_adl  = 1'b1;
    bus.i_execute      = 1'b1;
    bus.i_daa          = 1'b0;
    bus.i_dsa          = 1'b0;
    bus.i_carry_in     = 1'b1;
    bus.i_op           = 3'd3;
    bus.i_db  = 8'($urandom);
    bus.i_sb  = 8'($urandom);
    bus.i_adl = 8'($urandom) | 8'h01;
    cyc();
    cyc();
    sb_q.push_back({8'h00, 3'b000});
    chk("reset");
    rst_n = 1'b1;
    clr();
    exec(3'd3, 1'b0, 1'b0, 1'b0, {8'h00, 3'b000}, "ors_after_reset");

    load(8'h50, 8'h50, 1'b0);
    exec(3'd0, 1'b0, 1'b0, 1'b0, {8'hA0, 3'b010}, "sums_50_50");
    for (int i = 0; i < 5; i++) begin
      sb_q.push_back({8'hA0, 3'b010});
      cyc();
      chk("hold");
    end

    load(8'h58, 8'h46, 1'b0);
    exec(3'd0, 1'b1, 1'b1, 1'b0, {8'h05, 3'b110}, "bcd_add");
    exec(3'd0, 1'b1, 1'b1, 1'b1, {8'h9F, 3'b010}, "daa_dsa_none");
    exec(3'd1, 1'b1, 1'b1, 1'b0, {8'h40, 3'b000}, "daa_on_ands");

    load(8'h12, 8'h21, 1'b1);
    exec(3'd0, 1'b1, 1'b0, 1'b1, {8'h91, 3'b001}, "bcd_sub");

    load(8'h50, 8'h30, 1'b1);
    exec(3'd0, 1'b1, 1'b0, 1'b0, {8'h20, 3'b101}, "bin_sub");

    load(8'hA5, 8'hFF, 1'b0);
    exec(3'd2, 1'b1, 1'b0, 1'b0, {8'h5A, 3'b000}, "eors");
    exec(3'd5, 1'b1, 1'b0, 1'b0, {8'h00, 3'b000}, "reserved");

    load(8'h81, 8'h00, 1'b0);
    exec(3'd4, 1'b1, 1'b0, 1'b0, {8'hC0, 3'b100}, "srs");

    load(8'hF0, 8'h3C, 1'b0);
    bus.i_load_ai_zero = 1'b1;
    bus.i_load_bi_adl  = 1'b1;
    bus.i_adl          = 8'hFF;
    exec(3'd1, 1'b0, 1'b0, 1'b0, {8'h30, 3'b000}, "ands_with_load");
    exec(3'd3, 1'b0, 1'b0, 1'b0, {8'hFF, 3'b000}, "ors_new_ops");

    bus.i_adl          = 8'h11;
    bus.i_db           = 8'h22;
    bus.i_sb           = 8'h33;
    bus.i_load_bi_adl  = 1'b1;
    bus.i_load_bi_db   = 1'b1;
    bus.i_load_bi_db_n = 1'b1;
    bus.i_load_ai_zero = 1'b1;
    bus.i_load_ai_sb   = 1'b1;
    cyc();
    clr();
    exec(3'd3, 1'b0, 1'b0, 1'b0, {8'h11, 3'b000}, "bi_prio");

    load(8'h77, 8'h66, 1'b0);
    bus.i_sb         = 8'h12;
    bus.i_db         = 8'h34;
    bus.i_load_ai_sb = 1'b1;
    bus.i_load_bi_db = 1'b1;
    bus.i_execute    = 1'b1;
    bus.i_op         = 3'd3;
    rst_n            = 1'b0;
    sb_q.push_back({8'h00, 3'b000});
    cyc();
    clr();
    rst_n = 1'b1;
    chk("mid_reset");
    exec(3'd3, 1'b0, 1'b0, 1'b0, {8'h00, 3'b000}, "ors_post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
